// File: rtl/cvxif_alu_coprocessor.sv
// CV-X-IF ALU coprocessor: decodes custom-0 ALU ops, runs them through a fixed-latency
// pipeline and returns results in order via a credit-protected result buffer.
module cvxif_alu_coprocessor #(
  parameter int XLEN    = 64,
  parameter int IdWidth = 3,
  parameter int Latency = 2,
  parameter int Depth   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  input  logic [IdWidth-1:0] issue_id_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic [XLEN-1:0]    result_data_o
);

  localparam int CW = $clog2(Depth + 1);
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;

  function automatic logic [XLEN-1:0] alu(input logic [2:0] f3,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    case (f3)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a ^ b;
      3'b011:  return a & b;
      3'b100:  return a | b;
      default: return a << b[5:0];
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       accept;
  logic       unused_bits;

  assign opcode      = issue_instr_i[6:0];
  assign rd          = issue_instr_i[11:7];
  assign funct3      = issue_instr_i[14:12];
  assign funct7      = issue_instr_i[31:25];
  assign unused_bits = ^issue_instr_i[24:15];

  assign accept            = (opcode == 7'b0001011) && (funct7 == 7'd0) && (funct3 <= 3'd5);
  assign issue_accept_o    = accept;
  assign issue_writeback_o = accept;

  logic [CW-1:0] outstanding;
  logic          issue_fire;
  logic          acc_fire;
  logic          pop;

  assign issue_ready_o = (outstanding < CW'(Depth)) & ~flush_i;
  assign issue_fire    = issue_valid_i & issue_ready_o;
  assign acc_fire      = issue_fire & accept;

  // Execute pipeline: result computed at issue, then carried through Latency registers
  logic               vld_p  [Latency];
  logic [XLEN-1:0]    data_p [Latency];
  logic [4:0]         rd_p   [Latency];
  logic [IdWidth-1:0] id_p   [Latency];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < Latency; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= acc_fire;
      for (int i = 1; i < Latency; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    data_p[0] <= alu(funct3, issue_rs1_i, issue_rs2_i);
    rd_p[0]   <= rd;
    id_p[0]   <= issue_id_i;
    for (int i = 1; i < Latency; i++) begin
      data_p[i] <= data_p[i-1];
      rd_p[i]   <= rd_p[i-1];
      id_p[i]   <= id_p[i-1];
    end
  end

  // Result buffer: holds completed results while the core backpressures
  logic [XLEN-1:0]    mem_data [Depth];
  logic [4:0]         mem_rd   [Depth];
  logic [IdWidth-1:0] mem_id   [Depth];
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [CW-1:0]      fcnt;
  logic               fifo_empty;
  logic               vld_last;
  logic               fifo_push;
  logic               fifo_pop;

  assign vld_last       = vld_p[Latency-1];
  assign fifo_empty     = (fcnt == '0);
  assign result_valid_o = ~fifo_empty | vld_last;
  assign pop            = result_valid_o & result_ready_i;
  assign fifo_pop       = pop & ~fifo_empty;
  // With an empty buffer the last stage is presented directly; it only enters
  // the buffer if the core does not take it this cycle.
  assign fifo_push      = vld_last & ~(fifo_empty & result_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
    end else begin
      if (fifo_push) wptr <= ptr_next(wptr);
      if (fifo_pop)  rptr <= ptr_next(rptr);
      fcnt <= fcnt + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      mem_data[wptr] <= data_p[Latency-1];
      mem_rd[wptr]   <= rd_p[Latency-1];
      mem_id[wptr]   <= id_p[Latency-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      outstanding <= '0;
    end else begin
      case ({acc_fire, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_comb begin
    result_data_o = '0;
    result_rd_o   = '0;
    result_id_o   = '0;
    if (result_valid_o) begin
      if (fifo_empty) begin
        result_data_o = data_p[Latency-1];
        result_rd_o   = rd_p[Latency-1];
        result_id_o   = id_p[Latency-1];
      end else begin
        result_data_o = mem_data[rptr];
        result_rd_o   = mem_rd[rptr];
        result_id_o   = mem_id[rptr];
      end
    end
  end

endmodule
